branch_flush_ctrl: RTL and testbench
====================================

// Module: branch_flush_ctrl
// PURPOSE
// Sequences pipeline recovery after a not-taken-predicted bne resolves as taken in the 4-wide execute stage.
// Takes the four per-slot mispredict flags bne1..bne4 (slot 1 oldest) and the branch targets.
// Picks the oldest mispredicting slot, squashes younger slots in the same bundle and redirects fetch.
// Then holds the front end in a timed flush/refill sequence and counts mispredicts.
// PARAMETERS
// ADDR_W        32  width of branch target / redirect PC
// FLUSH_CYCLES  2   cycles front end held in flush after redirect (legal 1..15)
// CNT_W         16  width of saturating mispredict counter
// PORTS
// clk             in   1       single clock, all state on posedge
// rst             in   1       asynchronous, active-high reset
// ex_valid        in   1       execute bundle valid this cycle
// bne1..bne4      in   1 each  per-slot mispredict (branch taken, predicted not-taken)
// tgt1..tgt4      in   ADDR_W  per-slot branch target
// kill_mask       out  4       bit i-1 = squash slot i writeback this cycle (combinational)
// redirect_valid  out  1       one-cycle pulse: fetch must load redirect_pc
// redirect_pc     out  ADDR_W  target of oldest mispredicting slot (registered)
// flush_front     out  1       invalidate IF/ID/issue contents
// stall_fetch     out  1       fetch must not advance
// busy            out  1       controller not in IDLE
// mispredict_cnt  out  CNT_W   count of accepted mispredicts, saturates at all-ones
// BEHAVIOUR
// - Reset (async, any state, incl. mid-flush): state=IDLE, counter=0; all outputs 0.
// - trigger = ex_valid & (state==IDLE) & |{bne4,bne3,bne2,bne1}.
// - Winner w = lowest-indexed slot with bne set (slot 1 highest priority).
// - kill_mask (combinational, same cycle as trigger): bits for slots > w set; slot w and older clear.
//   Examples: w=1 -> 4'b1110; w=3 -> 4'b1000; w=4 -> 4'b0000. kill_mask=0 whenever trigger=0.
// - bne flags of slots younger than w are ignored (they are squashed); only one redirect per bundle.
// - States: IDLE, FLUSH, REFILL.
//   IDLE:   on trigger -> FLUSH; register redirect_pc=tgt_w; load down-counter with FLUSH_CYCLES-1;
//           increment mispredict_cnt unless already all-ones.
//   FLUSH:  redirect_valid=1 on first FLUSH cycle only. flush_front=1, stall_fetch=1 every FLUSH cycle.
//           Leave to REFILL when the down-counter reaches 0; otherwise decrement.
//   REFILL: exactly 1 cycle, stall_fetch=0, flush_front=0; fetch resumes from redirect_pc; -> IDLE.
// - busy = (state != IDLE).
// - Latency: trigger cycle T -> redirect_valid at T+1.
//   flush_front/stall_fetch high T+1..T+FLUSH_CYCLES; REFILL at T+FLUSH_CYCLES+1; IDLE next.
// - bne inputs during FLUSH/REFILL: ignored (wrong-path bundle), kill_mask stays 0, no count.
// - ex_valid=0 with bne set: no action.
// - redirect_pc holds its last value outside the pulse; it is 0 only after reset.
// - Counter wrap: mispredict_cnt at 2^CNT_W-1 stays there on further triggers.
// TESTING
// 1 Reset: assert rst mid-FLUSH -> state IDLE, all outputs 0 same cycle (async), counter 0.
// 2 Single mispredict: ex_valid=1, bne3=1, tgt3=32'h0000_0040 -> kill_mask=4'b1000 at T;
//   redirect_valid pulse with pc 0x40 at T+1; flush_front high T+1..T+2; IDLE at T+4 (FLUSH_CYCLES=2).
// 3 Priority: bne2=1, bne4=1, tgt2=0x100, tgt4=0x200 -> kill_mask=4'b1100, redirect_pc=0x100, cnt +1 only.
// 4 Busy ignore: bne1=1 on T+1 and T+2 after a trigger -> no kill, no second redirect, cnt unchanged.
// 5 Back-to-back: trigger, then new trigger exactly on first IDLE cycle -> accepted, second redirect at +1.
// 6 Saturation: CNT_W=2, issue 5 mispredicts -> mispredict_cnt reads 3 after the 3rd and stays 3.
//   Also: ex_valid=0 with bne1=1 -> nothing.

Source files
------------

// File: rtl/branch_flush_ctrl.sv
// Branch mispredict flush controller for a 4-wide execute stage.
// Picks the oldest mispredicting slot (slot 1 oldest), squashes younger slots
// in the same bundle, redirects fetch, then runs a timed FLUSH/REFILL sequence.
// It also keeps a saturating count of accepted mispredicts.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_valid                 execute bundle valid
//   bne1..bne4               per-slot mispredict flags
//   tgt1..tgt4               per-slot branch targets
//   kill_mask                combinational squash mask (bit i-1 = slot i)
//   redirect_valid           one-cycle fetch redirect pulse
//   redirect_pc              registered redirect target
//   flush_front, stall_fetch front-end flush / fetch stall
//   busy                     controller not idle
//   mispredict_cnt           saturating accepted-mispredict count
module branch_flush_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              bne1,
  input  logic              bne2,
  input  logic              bne3,
  input  logic              bne4,
  input  logic [ADDR_W-1:0] tgt1,
  input  logic [ADDR_W-1:0] tgt2,
  input  logic [ADDR_W-1:0] tgt3,
  input  logic [ADDR_W-1:0] tgt4,
  output logic [3:0]        kill_mask,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_front,
  output logic              stall_fetch,
  output logic              busy,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int unsigned DC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t            state_q;
  logic [DC_W-1:0]   dcnt_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              redirect_valid_q;
  logic              flush_front_q;
  logic              stall_fetch_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              trigger;
  logic [3:0]        win_kill;
  logic [ADDR_W-1:0] win_tgt;

  // Oldest-slot priority select; younger flags are don't-care once a winner exists.
  always_comb begin
    win_kill = 4'b0000;
    win_tgt  = tgt1;
    if (bne1) begin
      win_kill = 4'b1110;
      win_tgt  = tgt1;
    end else if (bne2) begin
      win_kill = 4'b1100;
      win_tgt  = tgt2;
    end else if (bne3) begin
      win_kill = 4'b1000;
      win_tgt  = tgt3;
    end else if (bne4) begin
      win_kill = 4'b0000;
      win_tgt  = tgt4;
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign trigger   = ~rst & ex_valid & (state_q == IDLE) & (bne1 | bne2 | bne3 | bne4);
  assign kill_mask = trigger ? win_kill : 4'b0000;

  // Sequencer: outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      dcnt_q           <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      flush_front_q    <= 1'b0;
      stall_fetch_q    <= 1'b0;
      busy_q           <= 1'b0;
      cnt_q            <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q          <= FLUSH;
            redirect_pc_q    <= win_tgt;
            dcnt_q           <= DC_W'(FLUSH_CYCLES - 1);
            redirect_valid_q <= 1'b1;
            flush_front_q    <= 1'b1;
            stall_fetch_q    <= 1'b1;
            busy_q           <= 1'b1;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (dcnt_q == '0) begin
            state_q       <= REFILL;
            flush_front_q <= 1'b0;
            stall_fetch_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q - DC_W'(1);
          end
        end
        REFILL: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          flush_front_q <= 1'b0;
          stall_fetch_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_front    = flush_front_q;
  assign stall_fetch    = stall_fetch_q;
  assign busy           = busy_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Bench for branch_flush_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-phase model. Two instances share stimulus: one with a
// 16-bit counter and one with a 2-bit counter for saturation.
module tb_branch_flush_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned FC = 2;

  logic          clk;
  logic          rst;
  logic          ex_valid;
  logic          bne1, bne2, bne3, bne4;
  logic [AW-1:0] tgt1, tgt2, tgt3, tgt4;

  logic [3:0]    kill_a, kill_b;
  logic          rv_a, rv_b, ff_a, ff_b, sf_a, sf_b, busy_a, busy_b;
  logic [AW-1:0] pc_a, pc_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;

  branch_flush_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .bne1(bne1), .bne2(bne2), .bne3(bne3), .bne4(bne4),
    .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3), .tgt4(tgt4),
    .kill_mask(kill_a), .redirect_valid(rv_a), .redirect_pc(pc_a),
    .flush_front(ff_a), .stall_fetch(sf_a), .busy(busy_a), .mispredict_cnt(cnt_a)
  );

  branch_flush_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .bne1(bne1), .bne2(bne2), .bne3(bne3), .bne4(bne4),
    .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3), .tgt4(tgt4),
    .kill_mask(kill_b), .redirect_valid(rv_b), .redirect_pc(pc_b),
    .flush_front(ff_b), .stall_fetch(sf_b), .busy(busy_b), .mispredict_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time since the last accepted mispredict determines every output.
  bit            has_trig;
  int            last_cyc;
  int            cyc;
  logic [AW-1:0] m_pc;
  int            m_cnt16;
  int            m_cnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int phase();
    return has_trig ? (cyc - last_cyc) : 1000;
  endfunction

  task automatic model_reset();
    has_trig = 1'b0;
    last_cyc = 0;
    m_pc     = '0;
    m_cnt16  = 0;
    m_cnt2   = 0;
  endtask

  task automatic check_regs();
    int  k;
    bit  e_rv, e_fl, e_busy;
    k      = phase();
    e_rv   = (k == 1);
    e_fl   = (k >= 1) && (k <= int'(FC));
    e_busy = (k >= 1) && (k <= int'(FC) + 1);
    chk("redirect_valid", 64'(rv_a), 64'(e_rv));
    chk("flush_front",    64'(ff_a), 64'(e_fl));
    chk("stall_fetch",    64'(sf_a), 64'(e_fl));
    chk("busy",           64'(busy_a), 64'(e_busy));
    chk("redirect_pc",    64'(pc_a), 64'(m_pc));
    chk("mispredict_cnt", 64'(cnt_a), 64'(m_cnt16));
    chk("sat_redirect_valid", 64'(rv_b), 64'(e_rv));
    chk("sat_busy",           64'(busy_b), 64'(e_busy));
    chk("sat_redirect_pc",    64'(pc_b), 64'(m_pc));
    chk("sat_cnt",            64'(cnt_b), 64'(m_cnt2));
  endtask

  // One clock cycle: apply inputs, check the combinational mask, clock, check registers.
  task automatic step(input logic ev, input logic [3:0] b,
                      input logic [AW-1:0] t1, input logic [AW-1:0] t2,
                      input logic [AW-1:0] t3, input logic [AW-1:0] t4);
    logic [AW-1:0] tg [4];
    logic [3:0]    ek;
    bit            trig;
    int            w;
    ex_valid = ev;
    {bne4, bne3, bne2, bne1} = b;
    tgt1 = t1; tgt2 = t2; tgt3 = t3; tgt4 = t4;
    tg = '{t1, t2, t3, t4};
    #1;
    trig = ev && (b != 4'b0000) && (phase() >= int'(FC) + 2);
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (b[i] && w < 0) w = i;
    end
    ek = 4'b0000;
    if (trig) ek = 4'hF << (w + 1);
    chk("kill_mask",     64'(kill_a), 64'(ek));
    chk("sat_kill_mask", 64'(kill_b), 64'(ek));
    if (trig) begin
      has_trig = 1'b1;
      last_cyc = cyc;
      m_pc     = tg[w];
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Assert reset away from a clock edge; everything must clear immediately.
  task automatic async_reset();
    rst      = 1'b1;
    ex_valid = 1'b1;
    {bne4, bne3, bne2, bne1} = 4'b0001;
    #1;
    model_reset();
    chk("rst_kill_mask",      64'(kill_a), 64'(0));
    chk("rst_redirect_valid", 64'(rv_a), 64'(0));
    chk("rst_flush_front",    64'(ff_a), 64'(0));
    chk("rst_stall_fetch",    64'(sf_a), 64'(0));
    chk("rst_busy",           64'(busy_a), 64'(0));
    chk("rst_redirect_pc",    64'(pc_a), 64'(0));
    chk("rst_cnt",            64'(cnt_a), 64'(0));
    chk("rst_sat_cnt",        64'(cnt_b), 64'(0));
    @(posedge clk);
    cyc++;
    #1;
    check_regs();
    rst      = 1'b0;
    ex_valid = 1'b0;
    {bne4, bne3, bne2, bne1} = 4'b0000;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    rst = 1'b1;
    ex_valid = 1'b0;
    {bne4, bne3, bne2, bne1} = 4'b0000;
    tgt1 = '0; tgt2 = '0; tgt3 = '0; tgt4 = '0;
    #1;
    chk("init_busy", 64'(busy_a), 64'(0));
    chk("init_cnt",  64'(cnt_a), 64'(0));
    @(posedge clk);
    cyc++;
    #1;
    check_regs();
    rst = 1'b0;
    idle(2);

    // Single mispredict in slot 3.
    step(1'b1, 4'b0100, 32'h11, 32'h22, 32'h0000_0040, 32'h44);
    idle(4);

    // Two flags: slot 2 wins over slot 4.
    step(1'b1, 4'b1010, 32'h1, 32'h100, 32'h3, 32'h200);
    // Wrong-path flags while busy are ignored.
    step(1'b1, 4'b0001, 32'hdead_0000, 32'h0, 32'h0, 32'h0);
    step(1'b1, 4'b0001, 32'hdead_0004, 32'h0, 32'h0, 32'h0);
    idle(2);

    // Back-to-back: second trigger lands on the first IDLE cycle.
    step(1'b1, 4'b0001, 32'h500, 32'h0, 32'h0, 32'h0);
    idle(FC + 1);
    step(1'b1, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h900);
    idle(4);

    // ex_valid low with a flag set does nothing.
    step(1'b0, 4'b0001, 32'h777, 32'h0, 32'h0, 32'h0);
    idle(1);

    // Reset mid-FLUSH.
    step(1'b1, 4'b0010, 32'h0, 32'h1234, 32'h0, 32'h0);
    async_reset();
    idle(2);

    // Random traffic; counter of the narrow instance saturates quickly.
    for (int n = 0; n < 500; n++) begin
      logic       ev;
      logic [3:0] b;
      ev = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step(ev, b, $urandom, $urandom, $urandom, $urandom);
      if (n == 250) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
